line_fill_memory: RTL and testbench

//  Backing-store responder on the memory side of the direct-mapped data cache.

---
 rtl/line_fill_memory.sv | 139 +++++++++++++
 tb/tb_line_fill_memory.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fill_memory.sv
// Line-fill backing store for the data cache: 4-word line reads and single-word
// write-throughs, each held off for a fixed LAT cycles while busy is high.
`timescale 1ns/1ps

module line_fill_lane #(
   parameter int VEC_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [VEC_W-1:0] d,
   output logic [VEC_W-1:0] q
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  q <= '0;
      else if (we) q <= d;
   end
endmodule

module line_fill_memory #(
   parameter int MEM_AW = 10,
   parameter int LAT    = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rd_req,
   input  logic [15:0]  rd_addr,
   output logic [127:0] rd_data,
   output logic         rd_valid,
   input  logic         wr_req,
   input  logic [15:0]  wr_addr,
   input  logic [31:0]  wr_data,
   output logic         wr_ack,
   output logic         busy
);
   localparam int          NUM_LANES = 4;
   localparam int          VEC_W     = 32;
   localparam int          DEPTH     = 1 << MEM_AW;
   localparam logic [3:0]  LAT_C     = 4'(LAT);

   typedef enum logic [1:0] {IDLE, WAIT, FILL, WRITE} state_t;

   state_t                         state;
   logic [3:0]                     count;
   logic [1:0]                     beat;
   logic [MEM_AW-3:0]              line_q;
   logic [MEM_AW-1:0]              wr_addr_q;
   logic [VEC_W-1:0]               wr_data_q;
   logic                           mem_we;
   logic [VEC_W-1:0]               fill_word;
   logic [NUM_LANES-1:0]           fill_we;
   logic [NUM_LANES-1:0][VEC_W-1:0] words;

   // Contents survive reset; only the time-0 image is zero.
   logic [VEC_W-1:0] mem [DEPTH] = '{default: '0};

   logic unused_addr_bits;
   assign unused_addr_bits = ^{rd_addr[15:MEM_AW], rd_addr[1:0], wr_addr[15:MEM_AW]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         beat      <= '0;
         busy      <= 1'b0;
         rd_valid  <= 1'b0;
         wr_ack    <= 1'b0;
         line_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         rd_valid <= 1'b0;
         wr_ack   <= 1'b0;
         case (state)
            IDLE: begin
               // Write wins a tie; the still-high rd_req is picked up on return.
               if (wr_req) begin
                  wr_addr_q <= wr_addr[MEM_AW-1:0];
                  wr_data_q <= wr_data;
                  busy      <= 1'b1;
                  count     <= LAT_C;
                  state     <= WRITE;
               end else if (rd_req) begin
                  line_q <= rd_addr[MEM_AW-1:2];
                  busy   <= 1'b1;
                  count  <= LAT_C;
                  state  <= WAIT;
               end
            end
            WRITE: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  wr_ack <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            WAIT: begin
               count <= count - 4'd1;
               if (count == 4'd1) begin
                  beat  <= '0;
                  state <= FILL;
               end
            end
            FILL: begin
               beat <= beat + 2'd1;
               if (beat == 2'd3) begin
                  rd_valid <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Commit edge is gated by state, so an async reset before it drops the write.
   assign mem_we = (state == WRITE) && (count == 4'd1);

   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_addr_q] <= wr_data_q;
   end

   assign fill_word = mem[{line_q, beat}];

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign fill_we[k] = (state == FILL) && (beat == 2'(k));
      line_fill_lane #(.VEC_W(VEC_W)) u_lane (
         .clk   (clk),
         .reset (reset),
         .we    (fill_we[k]),
         .d     (fill_word),
         .q     (words[k])
      );
   end

   assign rd_data = words;
endmodule

// File: tb/tb_line_fill_memory.sv
// Scoreboard bench for line_fill_memory: expected pulses are queued at issue time
// and checked (kind, cycle, data) by a monitor when rd_valid / wr_ack fire.
`timescale 1ns/1ps

module tb_line_fill_memory;
   localparam int MEM_AW = 10;
   localparam int LAT    = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         rd_req = 1'b0;
   logic [15:0]  rd_addr = '0;
   logic [127:0] rd_data;
   logic         rd_valid;
   logic         wr_req = 1'b0;
   logic [15:0]  wr_addr = '0;
   logic [31:0]  wr_data = '0;
   logic         wr_ack;
   logic         busy;

   typedef struct {
      bit           is_rd;
      int           cyc;
      logic [127:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        m_e;
   logic [31:0] model [1 << MEM_AW];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   line_fill_memory #(.MEM_AW(MEM_AW), .LAT(LAT)) dut (
      .clk      (clk),
      .reset    (reset),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .wr_req   (wr_req),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ack   (wr_ack),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] exp_line(input logic [15:0] a);
      logic [127:0] r;
      logic [7:0]   ln;
      ln = a[9:2];
      for (int k = 0; k < 4; k++) r[32*k +: 32] = model[{ln, 2'(k)}];
      return r;
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b1 && (rd_valid === 1'b1 || wr_ack === 1'b1)) begin
         n_chk++;
         if (rd_valid === 1'b1 && wr_ack === 1'b1) begin
            n_fail++;
            $display("FAIL pulse_overlap cyc=%0d rd_valid and wr_ack both high", cyc);
         end
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse cyc=%0d rd_valid=%b wr_ack=%b", cyc, rd_valid, wr_ack);
         end else begin
            m_e = sb.pop_front();
            n_chk++;
            if (m_e.is_rd !== rd_valid || m_e.cyc != cyc) begin
               n_fail++;
               $display("FAIL pulse_kind_time got rd=%b at cyc %0d, want rd=%b at cyc %0d",
                        rd_valid, cyc, m_e.is_rd, m_e.cyc);
            end
            if (m_e.is_rd && rd_valid === 1'b1) begin
               n_chk++;
               if (rd_data !== m_e.data) begin
                  n_fail++;
                  $display("FAIL rd_data got %h want %h", rd_data, m_e.data);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      @(negedge clk);
      while (busy !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_timeout busy=%b want 0", busy);
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout %0d pulses outstanding, want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic issue_wr(input logic [15:0] a, input logic [31:0] d, input bit push);
      exp_t e;
      wait_idle();
      wr_req = 1'b1; wr_addr = a; wr_data = d;
      if (push) begin
         e.is_rd = 1'b0; e.cyc = cyc + 1 + LAT; e.data = '0;
         sb.push_back(e);
         model[a[9:0]] = d;
      end
      @(negedge clk);
      wr_req = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_accept busy=%b want 1", busy);
      end
   endtask

   task automatic issue_rd(input logic [15:0] a);
      exp_t e;
      wait_idle();
      rd_req = 1'b1; rd_addr = a;
      e.is_rd = 1'b1; e.cyc = cyc + 1 + LAT + 4; e.data = exp_line(a);
      sb.push_back(e);
      @(negedge clk);
      rd_req = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_accept busy=%b want 1", busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; rd_req = 1'b1; rd_addr = 16'h0004;
      repeat (3) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || rd_valid !== 1'b0 || wr_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl busy=%b rd_valid=%b wr_ack=%b want 000", busy, rd_valid, wr_ack);
      end
      n_chk++;
      if (rd_data !== 128'h0) begin
         n_fail++;
         $display("FAIL reset_rd_data got %h want 0", rd_data);
      end
      rd_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release busy=%b want 0", busy);
      end
   endtask

   task automatic test_write_read();
      issue_wr(16'h0005, 32'hDEADBEEF, 1'b1);
      issue_rd(16'h0006);
      wait_drain();
      n_chk++;
      if (rd_data !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin
         n_fail++;
         $display("FAIL write_read_line got %h want word1=deadbeef", rd_data);
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (rd_data !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin
         n_fail++;
         $display("FAIL rd_data_hold got %h want word1=deadbeef", rd_data);
      end
   endtask

   task automatic test_simultaneous();
      exp_t e;
      wait_idle();
      rd_req = 1'b1; rd_addr = 16'h0010;
      wr_req = 1'b1; wr_addr = 16'h0011; wr_data = 32'h12345678;
      e.is_rd = 1'b0; e.cyc = cyc + 1 + LAT; e.data = '0;
      sb.push_back(e);
      model[10'h011] = 32'h12345678;
      e.is_rd = 1'b1; e.cyc = cyc + 1 + LAT + 1 + LAT + 4; e.data = exp_line(16'h0010);
      sb.push_back(e);
      @(negedge clk);
      wr_req = 1'b0;
      repeat (LAT + 1) @(negedge clk);
      rd_req = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_rd_accept busy=%b want 1", busy);
      end
      wait_drain();
      n_chk++;
      if (rd_data[63:32] !== 32'h12345678) begin
         n_fail++;
         $display("FAIL simul_word1 got %h want 12345678", rd_data[63:32]);
      end
   endtask

   task automatic test_alias();
      issue_wr(16'h0400, 32'hA5A5A5A5, 1'b1);
      issue_rd(16'h0000);
      wait_drain();
      n_chk++;
      if (rd_data[31:0] !== 32'hA5A5A5A5) begin
         n_fail++;
         $display("FAIL alias_word0 got %h want a5a5a5a5", rd_data[31:0]);
      end
   endtask

   task automatic test_write_abort();
      issue_wr(16'h0020, 32'hFFFFFFFF, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_chk++;
      if (busy !== 1'b0 || wr_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_abort busy=%b wr_ack=%b want 00", busy, wr_ack);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (LAT + 4) @(negedge clk);
      issue_rd(16'h0020);
      wait_drain();
      n_chk++;
      if (rd_data[31:0] !== 32'h0) begin
         n_fail++;
         $display("FAIL wr_abort_word0 got %h want 0", rd_data[31:0]);
      end
   endtask

   task automatic test_fill_abort();
      wait_idle();
      rd_req = 1'b1; rd_addr = 16'h0004;
      @(negedge clk);
      rd_req = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      n_chk++;
      if (rd_data[63:32] !== 32'hDEADBEEF || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_progress word1=%h busy=%b want deadbeef 1", rd_data[63:32], busy);
      end
      reset = 1'b0;
      #1;
      n_chk++;
      if (rd_data !== 128'h0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_abort rd_data=%h busy=%b want 0 0", rd_data, busy);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (LAT + 6) @(negedge clk);
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      int   bl = 0;
      int   t = 0;
      wait_idle();
      rd_req = 1'b1; rd_addr = 16'h0004;
      e.is_rd = 1'b1; e.cyc = cyc + 1 + LAT + 4; e.data = exp_line(16'h0004);
      sb.push_back(e);
      @(negedge clk);
      rd_req = 1'b0;
      while (busy === 1'b1 && t < 100) begin
         bl++;
         if (bl == 2) begin rd_req = 1'b1; rd_addr = 16'h0030; end
         if (bl == 4) rd_req = 1'b0;
         @(negedge clk);
         t++;
      end
      rd_req = 1'b0;
      n_chk++;
      if (bl != LAT + 4) begin
         n_fail++;
         $display("FAIL busy_len got %0d cycles want %0d", bl, LAT + 4);
      end
      repeat (2 * LAT + 10) @(negedge clk);
      wait_drain();
      n_chk++;
      if (busy !== 1'b0 || rd_data !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin
         n_fail++;
         $display("FAIL busy_ignore busy=%b rd_data=%h want 0 and line 0x0004", busy, rd_data);
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << MEM_AW); i++) model[i] = '0;
      test_reset();
      test_write_read();
      test_simultaneous();
      test_alias();
      test_write_abort();
      test_fill_abort();
      test_busy_ignore();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation ran past time limit");
      $fatal(1, "watchdog");
   end
endmodule
